// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO word/beat widths and lane-count types for the read-side packer
package fifo_pkg;
  localparam int FIFO_WIDTH = 16;
  localparam int PACK = 2;
  localparam int CNT_W = $clog2(PACK + 1);
  typedef logic [FIFO_WIDTH-1:0] word_t;
  typedef logic [FIFO_WIDTH*PACK-1:0] beat_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/pack_out_reg.sv
// pack_out_reg: valid/ready holding register for packed output beats
module pack_out_reg
  import fifo_pkg::*;
#(
  parameter int W = $bits(beat_t),
  parameter int CW = $bits(cnt_t)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  data,
  input  logic [CW-1:0] count,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] out_count,
  output logic          free
);
  assign free = !out_valid || out_ready;
  // load a new beat when offered, otherwise drop valid once the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= data;
      out_count <= count;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains a FIFO and packs PACK words per valid/ready output beat, with flush
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
  parameter int PACK = fifo_pkg::PACK
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fifo_empty,
  input  logic [FIFO_WIDTH-1:0]        fifo_data_out,
  output logic                         fifo_rd_en,
  input  logic                         flush,
  output logic [FIFO_WIDTH*PACK-1:0]   out_data,
  output logic [$clog2(PACK+1)-1:0]    out_count,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);
  localparam int CW = $clog2(PACK + 1);
  logic [FIFO_WIDTH-1:0] acc [PACK];
  logic [CW-1:0] acc_cnt, eff_cnt;
  logic inflight, flush_pend, free, full, part, xfer, pend_clr;
  logic [FIFO_WIDTH*PACK-1:0] acc_beat;
  // transfer decision and read request; a read is issued only if its word is sure to fit
  always_comb begin
    full = acc_cnt == CW'(PACK);
    part = flush_pend && !inflight && acc_cnt != '0;
    xfer = (full || part) && free;
    eff_cnt = xfer ? '0 : acc_cnt;
    pend_clr = (xfer && !full) || (acc_cnt == '0 && !inflight);
    fifo_rd_en = !rst && !fifo_empty && !flush_pend && (int'(eff_cnt) + int'(inflight) < PACK);
  end
  // present only the filled lanes; unused lanes read as zero
  always_comb begin
    acc_beat = '0;
    for (int i = 0; i < PACK; i++)
      if (CW'(i) < acc_cnt) acc_beat[i*FIFO_WIDTH +: FIFO_WIDTH] = acc[i];
  end
  // lane count, in-flight tracking and pending flush
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt    <= '0;
      inflight   <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      acc_cnt    <= eff_cnt + CW'(inflight);
      inflight   <= fifo_rd_en;
      flush_pend <= flush_pend ? !pend_clr : flush;
    end
  end
  // returning word lands in the next free lane, or lane 0 when the lanes are moving out
  always_ff @(posedge clk) begin
    for (int i = 0; i < PACK; i++)
      if (inflight && eff_cnt == CW'(i)) acc[i] <= fifo_data_out;
  end
  pack_out_reg #(.W(FIFO_WIDTH*PACK), .CW(CW)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (xfer),
    .data      (acc_beat),
    .count     (acc_cnt),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_count (out_count),
    .free      (free)
  );
  assign busy = acc_cnt != '0 || inflight || out_valid;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: scoreboard bench with a FIFO model and a word-grouping reference model
module tb_fifo_rd_packer;
  localparam int P = 2;
  logic clk, rst, fifo_empty, fifo_rd_en, flush, out_valid, out_ready, busy;
  logic [15:0] fifo_data_out;
  logic [31:0] out_data;
  logic [1:0] out_count;
  logic [15:0] mem [0:2047];
  int wp = 0, rp = 0, cyc = 0, total = 0, bad = 0;
  logic uflow = 1'b0;
  logic [31:0] exp_d[$];
  logic [1:0] exp_c[$];
  logic [15:0] pend[$];

  fifo_rd_packer dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
    .fifo_rd_en(fifo_rd_en), .flush(flush), .out_data(out_data), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  assign fifo_empty = (wp == rp);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst) rp <= wp;
    else if (fifo_rd_en) begin
      if (rp == wp) uflow <= 1'b1;
      else begin
        fifo_data_out <= mem[rp];
        rp <= rp + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_flush();
    logic [31:0] b;
    if (pend.size() != 0) begin
      b = '0;
      for (int i = 0; i < pend.size(); i++) b[i*16 +: 16] = pend[i];
      exp_d.push_back(b);
      exp_c.push_back(2'(pend.size()));
      pend.delete();
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    mem[wp] = w;
    wp++;
    pend.push_back(w);
    if (pend.size() == P) model_flush();
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      #1;
      if (!rst && out_valid && out_ready) begin
        if (exp_d.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected: got %h/%0d want none", out_data, out_count);
        end else begin
          check("beat_data", out_data, exp_d.pop_front());
          check("beat_count", out_count, exp_c.pop_front());
        end
      end
    end
  endtask

  task automatic wait_idle(input bit rnd);
    int n = 0;
    while ((busy || wp != rp) && n < 400) begin
      @(negedge clk);
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    check("idle_reached", n < 400, 1);
  endtask

  task automatic do_flush(input bit rnd);
    int n = 0;
    while (wp != rp && n < 400) begin
      @(negedge clk);
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end
    check("flush_drain", n < 400, 1);
    flush = 1;
    model_flush();
    @(negedge clk);
    flush = 0;
    wait_idle(rnd);
  endtask

  initial begin
    int c0, n, r0;
    rst = 1;
    flush = 0;
    out_ready = 1;
    fork
      monitor();
    join_none
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      mem[wp] = 16'hBEEF;
      wp++;
    end
    #1;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_count", out_count, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    check("rst_rd_en2", fifo_rd_en, 0);
    rst = 0;

    @(negedge clk);
    push_word(16'h1111);
    push_word(16'h2222);
    #1;
    c0 = cyc;
    check("basic_rd_en", fifo_rd_en, 1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("basic_latency", cyc - c0, 4);
    @(negedge clk);
    check("basic_one_cycle", out_valid, 0);

    @(negedge clk);
    out_ready = 0;
    r0 = rp;
    for (int i = 1; i <= 6; i++) push_word(16'(i));
    repeat (20) @(negedge clk);
    check("bp_reads", rp - r0, 4);
    check("bp_rd_en", fifo_rd_en, 0);
    check("bp_valid", out_valid, 1);
    check("bp_data", out_data, 32'h0002_0001);
    check("bp_count", out_count, 2);
    check("bp_busy", busy, 1);
    out_ready = 1;
    wait_idle(0);

    @(negedge clk);
    push_word(16'h000A);
    push_word(16'h000B);
    push_word(16'h000C);
    do_flush(0);
    check("tail_busy", busy, 0);

    @(negedge clk);
    push_word(16'h00C3);
    do_flush(0);
    check("inflight_busy", busy, 0);

    do_flush(0);
    repeat (3) @(negedge clk);
    check("idle_flush_valid", out_valid, 0);
    check("idle_flush_busy", busy, 0);

    push_word(16'h0055);
    push_word(16'h0066);
    push_word(16'h0077);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    exp_d.delete();
    exp_c.delete();
    pend.delete();
    @(negedge clk);
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    rst = 0;
    push_word(16'h0101);
    push_word(16'h0202);
    wait_idle(0);

    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) push_word(16'($urandom));
      if ($urandom_range(0, 40) == 0) do_flush(1);
    end
    do_flush(1);
    out_ready = 1;
    wait_idle(0);
    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_d.size(), 0);
    check("no_underflow", uflow, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
